// File: rtl/api_miner_resp_if.sv
// ============================================================================
// Module      : api_miner_resp_if
// Description : Serial-link pins plus the work and nonce side-band of the miner.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

interface api_miner_resp_if;
  logic        load;
  logic        sck;
  logic        mosi;
  logic        miso;
  logic        work_valid;
  logic [31:0] work_data;
  logic [4:0]  work_idx;
  logic        frame_done;
  logic        frame_err;
  logic        nonce_push;
  logic [31:0] nonce_din;
  logic        nonce_full;
  logic        nonce_ovf;

  modport slave (
    input  load, sck, mosi, nonce_push, nonce_din,
    output miso, work_valid, work_data, work_idx, frame_done, frame_err,
           nonce_full, nonce_ovf
  );

  modport master (
    output load, sck, mosi, nonce_push, nonce_din,
    input  miso, work_valid, work_data, work_idx, frame_done, frame_err,
           nonce_full, nonce_ovf
  );
endinterface

`default_nettype wire

// File: rtl/api_miner_resp.sv
// ============================================================================
// Module      : api_miner_resp
// Description : Miner-side responder for the API serial link. Oversamples
//               load/sck/mosi, deserialises work words and shifts queued
//               nonce words out on miso. Define API_RESP_HDR_EN to prefix
//               every reply frame with a {16'h5A5A, 8'h00, count} header.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module api_miner_resp #(
  parameter int          WORK_LEN  = 23,
  parameter int          NONCE_DEP = 16,
  parameter logic [31:0] IDLE_WORD = 32'hFFFF_FFFF
) (
  input  wire logic CLK_I,
  input  wire logic RST_I,
  api_miner_resp_if.slave api
);

  localparam int         PW      = $clog2(NONCE_DEP);
  localparam logic [7:0] LP_WLEN = 8'(WORK_LEN);

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_SHIFT = 2'd1, ST_CLOSE = 2'd2} state_t;

  state_t      state_q, state_d;
  logic [1:0]  load_q;
  logic [2:0]  sck_q;
  logic [1:0]  mosi_q;
  logic [4:0]  bit_q, bit_d;
  logic [7:0]  word_q, word_d;
  logic [31:0] rx_q, rx_d;
  logic [31:0] tx_q, tx_d;
  logic [4:0]  txcnt_q, txcnt_d;
  logic        txfifo_q, txfifo_d;
  logic        miso_q, miso_d;
  logic        wv_q, wv_d;
  logic [31:0] wdata_q, wdata_d;
  logic [4:0]  widx_q, widx_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        ovf_q;
  logic [31:0] mem_q [NONCE_DEP];
  logic [PW-1:0] wr_q, rd_q;
  logic [PW:0]   cnt_q;

  logic        w_load, w_mosi, w_sck_rise, w_sck_fall;
  logic        w_empty, w_full, w_pop, w_push_ok;
  logic [31:0] w_head, w_head_nxt;
  logic [PW-1:0] w_rd_inc;

  // mosi shares the sck pipeline depth so its value is aligned with the edge strobe
  assign w_load     = load_q[1];
  assign w_mosi     = mosi_q[1];
  assign w_sck_rise = sck_q[1] & ~sck_q[2];
  assign w_sck_fall = ~sck_q[1] & sck_q[2];

  assign w_empty    = (cnt_q == '0);
  assign w_full     = (cnt_q == (PW+1)'(NONCE_DEP));
  assign w_rd_inc   = rd_q + PW'(1);
  assign w_head     = mem_q[rd_q];
  assign w_head_nxt = (cnt_q > (PW+1)'(1)) ? mem_q[w_rd_inc] : IDLE_WORD;
  assign w_push_ok  = api.nonce_push & (~w_full | w_pop);

  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      load_q   <= '0;
      sck_q    <= '0;
      mosi_q   <= '0;
      state_q  <= ST_IDLE;
      bit_q    <= '0;
      word_q   <= '0;
      rx_q     <= '0;
      tx_q     <= IDLE_WORD;
      txcnt_q  <= '0;
      txfifo_q <= 1'b0;
      miso_q   <= 1'b1;
      wv_q     <= 1'b0;
      wdata_q  <= '0;
      widx_q   <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      ovf_q    <= 1'b0;
      wr_q     <= '0;
      rd_q     <= '0;
      cnt_q    <= '0;
    end else begin
      load_q   <= {load_q[0], api.load};
      sck_q    <= {sck_q[1:0], api.sck};
      mosi_q   <= {mosi_q[0], api.mosi};
      state_q  <= state_d;
      bit_q    <= bit_d;
      word_q   <= word_d;
      rx_q     <= rx_d;
      tx_q     <= tx_d;
      txcnt_q  <= txcnt_d;
      txfifo_q <= txfifo_d;
      miso_q   <= miso_d;
      wv_q     <= wv_d;
      wdata_q  <= wdata_d;
      widx_q   <= widx_d;
      done_q   <= done_d;
      err_q    <= err_d;
      if (api.nonce_push && w_full && !w_pop) ovf_q <= 1'b1;
      if (w_push_ok) wr_q <= wr_q + PW'(1);
      if (w_pop)     rd_q <= w_rd_inc;
      case ({w_push_ok, w_pop})
        2'b10:   cnt_q <= cnt_q + (PW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (PW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Storage needs no reset: pointers and count define what is valid
  always_ff @(posedge CLK_I) begin
    if (w_push_ok) mem_q[wr_q] <= api.nonce_din;
  end

  always_comb begin
    state_d  = state_q;
    bit_d    = bit_q;
    word_d   = word_q;
    rx_d     = rx_q;
    tx_d     = tx_q;
    txcnt_d  = txcnt_q;
    txfifo_d = txfifo_q;
    miso_d   = miso_q;
    wv_d     = 1'b0;
    wdata_d  = wdata_q;
    widx_d   = widx_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    w_pop    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        miso_d = 1'b1;
        if (w_load) begin
          state_d = ST_SHIFT;
          bit_d   = '0;
          word_d  = '0;
          txcnt_d = '0;
`ifdef API_RESP_HDR_EN
          tx_d     = {16'h5A5A, 8'h00, (32'(cnt_q) > 32'd255) ? 8'hFF : 8'(cnt_q)};
          txfifo_d = 1'b0;
`else
          tx_d     = w_empty ? IDLE_WORD : w_head;
          txfifo_d = ~w_empty;
`endif
          miso_d = tx_d[31];
        end
      end
      ST_SHIFT: begin
        if (!w_load) begin
          state_d = ST_CLOSE;
        end else begin
          if (w_sck_rise) begin
            rx_d  = {rx_q[30:0], w_mosi};
            bit_d = bit_q + 5'd1;
            if (bit_q == 5'd31) begin
              wv_d    = 1'b1;
              wdata_d = {rx_q[30:0], w_mosi};
              widx_d  = (word_q > 8'd31) ? 5'd31 : word_q[4:0];
              if (word_q != 8'hFF) word_d = word_q + 8'd1;
            end
          end
          if (w_sck_fall) begin
            if (txcnt_q == 5'd31) begin
              // Whole word is out: retire it from the FIFO before reloading
              w_pop    = txfifo_q;
              tx_d     = txfifo_q ? w_head_nxt : (w_empty ? IDLE_WORD : w_head);
              txfifo_d = txfifo_q ? (cnt_q > (PW+1)'(1)) : ~w_empty;
              miso_d   = tx_d[31];
              txcnt_d  = '0;
            end else begin
              tx_d    = {tx_q[30:0], 1'b0};
              miso_d  = tx_q[30];
              txcnt_d = txcnt_q + 5'd1;
            end
          end
        end
      end
      ST_CLOSE: begin
        miso_d  = 1'b1;
        done_d  = (bit_q == 5'd0) && (word_q == LP_WLEN);
        err_d   = ~done_d;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign api.miso       = miso_q;
  assign api.work_valid = wv_q;
  assign api.work_data  = wdata_q;
  assign api.work_idx   = widx_q;
  assign api.frame_done = done_q;
  assign api.frame_err  = err_q;
  assign api.nonce_full = w_full;
  assign api.nonce_ovf  = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_api_miner_resp.sv
// ============================================================================
// Module      : tb_api_miner_resp
// Description : Self-checking bench for api_miner_resp against a queue model.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_api_miner_resp;

  localparam int          WORK_LEN  = 23;
  localparam int          NONCE_DEP = 16;
  localparam logic [31:0] IDLE_WORD = 32'hFFFF_FFFF;

  logic clk;
  logic rst_n;
  api_miner_resp_if bus ();

  api_miner_resp #(
    .WORK_LEN (WORK_LEN),
    .NONCE_DEP(NONCE_DEP),
    .IDLE_WORD(IDLE_WORD)
  ) u_dut (
    .CLK_I(clk),
    .RST_I(rst_n),
    .api  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] mosi_w [32];
  logic [31:0] mq [$];
  logic        ovf_exp = 1'b0;

  logic [36:0] mon_q [$];
  int          n_done = 0;
  int          n_err  = 0;

  always @(negedge clk) begin
    if (bus.work_valid) mon_q.push_back({bus.work_idx, bus.work_data});
    if (bus.frame_done) n_done++;
    if (bus.frame_err)  n_err++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push_nonce(input logic [31:0] v);
    @(negedge clk);
    bus.nonce_push = 1'b1;
    bus.nonce_din  = v;
    @(negedge clk);
    bus.nonce_push = 1'b0;
    if (mq.size() < NONCE_DEP) mq.push_back(v);
    else ovf_exp = 1'b1;
  endtask

  task automatic check_reset_values();
    check("rst_miso",  64'(bus.miso), 64'd1);
    check("rst_wv",    64'(bus.work_valid), 64'd0);
    check("rst_wdata", 64'(bus.work_data), 64'd0);
    check("rst_widx",  64'(bus.work_idx), 64'd0);
    check("rst_done",  64'(bus.frame_done), 64'd0);
    check("rst_err",   64'(bus.frame_err), 64'd0);
    check("rst_ovf",   64'(bus.nonce_ovf), 64'd0);
    check("rst_full",  64'(bus.nonce_full), 64'd0);
  endtask

  task automatic run_frame(input int nbits);
    int          base_v, base_d, base_e, nwords, rem;
    logic [31:0] cur, exp_w, hdr_w;
    logic [31:0] got_tx [$];
    logic [63:0] mask;
    logic [36:0] ent;
    base_v = mon_q.size();
    base_d = n_done;
    base_e = n_err;
    hdr_w  = {16'h5A5A, 8'h00, (mq.size() > 255) ? 8'hFF : 8'(mq.size())};
    cur    = '0;
    @(negedge clk);
    bus.load = 1'b1;
    #100;
    for (int b = 0; b < nbits; b++) begin
      bus.mosi = mosi_w[b/32][31 - (b % 32)];
      #60;
      cur = {cur[30:0], bus.miso};
      bus.sck = 1'b1;
      if ((b % 32) == 31) got_tx.push_back(cur);
      #60;
      bus.sck = 1'b0;
    end
    #100;
    bus.load = 1'b0;
    #200;

    nwords = nbits / 32;
    rem    = nbits % 32;
    check("strobes", 64'(mon_q.size() - base_v), 64'(nwords));
    for (int k = 0; k < nwords && (base_v + k) < mon_q.size(); k++) begin
      ent = mon_q[base_v + k];
      check($sformatf("wdata[%0d]", k), 64'(ent[31:0]), 64'(mosi_w[k]));
      check($sformatf("widx[%0d]", k),  64'(ent[36:32]), 64'((k > 31) ? 31 : k));
    end
    for (int k = 0; k < got_tx.size(); k++) begin
`ifdef API_RESP_HDR_EN
      if (k == 0) exp_w = hdr_w;
      else
`endif
      exp_w = (mq.size() > 0) ? mq.pop_front() : IDLE_WORD;
      check($sformatf("miso_word[%0d]", k), 64'(got_tx[k]), 64'(exp_w));
    end
    if (rem != 0) begin
      // A partly sent word is only peeked: it must still be queued afterwards
`ifdef API_RESP_HDR_EN
      if (nwords == 0) exp_w = hdr_w;
      else
`endif
      exp_w = (mq.size() > 0) ? mq[0] : IDLE_WORD;
      mask = (64'd1 << rem) - 64'd1;
      check("miso_partial", 64'(cur) & mask, (64'(exp_w) >> (32 - rem)) & mask);
    end
    check("frame_done", 64'(n_done - base_d), (nbits == WORK_LEN*32) ? 64'd1 : 64'd0);
    check("frame_err",  64'(n_err - base_e),  (nbits == WORK_LEN*32) ? 64'd0 : 64'd1);
  endtask

  task automatic rand_words();
    for (int i = 0; i < 32; i++) mosi_w[i] = $urandom;
  endtask

  int base_v;

  initial begin
    rst_n          = 1'b0;
    bus.load       = 1'b0;
    bus.sck        = 1'b0;
    bus.mosi       = 1'b0;
    bus.nonce_push = 1'b0;
    bus.nonce_din  = '0;
    repeat (4) @(negedge clk);
    check_reset_values();
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check_reset_values();

    // Directed work pattern, empty FIFO
    for (int i = 0; i < 32; i++) mosi_w[i] = 32'h1000_0000 + i;
    run_frame(WORK_LEN*32);

    // Two nonces drained in one frame
    push_nonce(32'hDEAD_BEEF);
    push_nonce(32'h0000_1234);
    rand_words();
    run_frame(WORK_LEN*32);
    check("fifo_drained", 64'(mq.size()), 64'd0);

    // Short frame leaves the unfinished nonce queued
    push_nonce($urandom);
    push_nonce($urandom);
    rand_words();
    run_frame(40);
    rand_words();
    run_frame(WORK_LEN*32);

    // Overflow: fill to depth then one more
    for (int i = 0; i < NONCE_DEP; i++) push_nonce($urandom);
    @(negedge clk);
    check("full_at_depth", 64'(bus.nonce_full), 64'd1);
    check("ovf_before", 64'(bus.nonce_ovf), 64'd0);
    push_nonce($urandom);
    @(negedge clk);
    check("ovf_after", 64'(bus.nonce_ovf), 64'(ovf_exp));
    check("full_after", 64'(bus.nonce_full), 64'd1);
    rand_words();
    run_frame(WORK_LEN*32);
    check("ovf_sticky", 64'(bus.nonce_ovf), 64'd1);
    check("not_full", 64'(bus.nonce_full), 64'd0);

    // Over-long frame
    rand_words();
    run_frame((WORK_LEN+1)*32);

    // Reset mid-word with a nonce queued
    push_nonce($urandom);
    base_v = mon_q.size();
    rand_words();
    @(negedge clk);
    bus.load = 1'b1;
    #100;
    for (int b = 0; b < 20; b++) begin
      bus.mosi = mosi_w[0][31 - b];
      #60 bus.sck = 1'b1;
      #60 bus.sck = 1'b0;
    end
    @(negedge clk);
    rst_n    = 1'b0;
    bus.load = 1'b0;
    @(negedge clk);
    check_reset_values();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    mq.delete();
    ovf_exp = 1'b0;
    repeat (6) @(negedge clk);
    check("rst_no_strobe", 64'(mon_q.size() - base_v), 64'd0);
    rand_words();
    run_frame(WORK_LEN*32);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
